// File: rtl/tape_ram_injector.sv
// -----------------------------------------------------------------------------
// tape_ram_injector
//   Takes the byte-write stream of the .TAP parser and commits each byte into
//   Lynx main RAM by taking the Z80 bus (BUSRQ/BUSAK). Address 16'hFFFF is the
//   bank-switch port: writes to it update bank_reg and never strobe RAM.
//   A small FIFO absorbs the difference between the download rate and the
//   bus-grant latency.
//
// Optional feature macro: TAPE_CHECKSUM_EN
//   When defined, checksum accumulates (mod 256) every byte written to RAM.
//   When undefined, checksum is tied to 8'h00.
//
// Ports
//   clk, reset            clock, synchronous active-high reset
//   tape_wr               write-enable level from the parser (held across bytes)
//   tape_addr, tape_dout  target address and byte
//   busak_n               Z80 bus acknowledge (active low)
//   busrq_n               Z80 bus request (active low)
//   ram_addr, ram_din     RAM address/data, valid one cycle before and while ram_we
//   ram_we                RAM write strobe, WR_CYCLES cycles per byte
//   bank_reg              last byte written to the bank-switch port
//   overflow              sticky: a byte was dropped because the FIFO was full
//   checksum              running sum of RAM bytes (see macro above)
//   dbg_state             current FSM state encoding
//
// Handshake: a FIFO entry is consumed (popped) only in a cycle where the
// injector owns the bus (busak_n low seen in REQ, or already in NEXT/HOLD)
// and the FIFO is non-empty; push happens one cycle after a write is captured.
// -----------------------------------------------------------------------------
module tape_ram_injector #(
  parameter int FIFO_AW     = 2,
  parameter int WR_CYCLES   = 2,
  parameter int HOLD_CYCLES = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        tape_wr,
  input  logic [15:0] tape_addr,
  input  logic [7:0]  tape_dout,
  input  logic        busak_n,
  output logic        busrq_n,
  output logic [15:0] ram_addr,
  output logic [7:0]  ram_din,
  output logic        ram_we,
  output logic [7:0]  bank_reg,
  output logic        overflow,
  output logic [7:0]  checksum,
  output logic [2:0]  dbg_state
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam int HW    = $clog2(HOLD_CYCLES + 1);
  localparam logic [FIFO_AW:0] PTR_ONE = 1;
  localparam logic [15:0]      BANK_PORT = 16'hFFFF;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_WRITE = 3'd2,
    S_NEXT  = 3'd3,
    S_HOLD  = 3'd4
  } state_t;

  // ---------------- capture ----------------
  logic [23:0] pair;
  logic        accept;
  logic        prev_wr_q;
  logic [23:0] last_q;
  logic [23:0] cap_q;
  logic        cap_vld_q;

  assign pair   = {tape_addr, tape_dout};
  // tape_wr is a level: a new byte is a rising level or a changed pair
  assign accept = tape_wr && (!prev_wr_q || (pair != last_q));

  always_ff @(posedge clk) begin
    if (reset) begin
      prev_wr_q <= 1'b0;
      last_q    <= '0;
      cap_q     <= '0;
      cap_vld_q <= 1'b0;
    end else begin
      prev_wr_q <= tape_wr;
      cap_vld_q <= accept;
      if (accept) begin
        last_q <= pair;
        cap_q  <= pair;
      end
    end
  end

  // ---------------- FIFO ----------------
  logic [23:0]      mem_q [DEPTH];
  logic [FIFO_AW:0] wptr_q, rptr_q;
  logic             empty, full, push, pop;
  logic [23:0]      head;

  assign empty = (wptr_q == rptr_q);
  assign full  = (wptr_q[FIFO_AW] != rptr_q[FIFO_AW]) &&
                 (wptr_q[FIFO_AW-1:0] == rptr_q[FIFO_AW-1:0]);
  assign push  = cap_vld_q && !full;
  assign head  = mem_q[rptr_q[FIFO_AW-1:0]];

  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q[FIFO_AW-1:0]] <= cap_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      overflow   <= 1'b0;
    end else begin
      if (push) wptr_q <= wptr_q + PTR_ONE;
      if (pop)  rptr_q <= rptr_q + PTR_ONE;
      if (cap_vld_q && full) overflow <= 1'b1;
    end
  end

  // ---------------- FSM ----------------
  state_t        state_q;
  logic [23:0]   work_q;
  logic [3:0]    wr_cnt_q;
  logic [HW-1:0] hold_cnt_q;
`ifdef TAPE_CHECKSUM_EN
  logic [7:0]    checksum_q;
  assign checksum = checksum_q;
`else
  assign checksum = 8'h00;
`endif

  assign dbg_state = state_q;

  always_comb begin
    pop = 1'b0;
    case (state_q)
      S_REQ:          pop = !busak_n && !empty;
      S_NEXT, S_HOLD: pop = !empty;
      default:        pop = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      busrq_n    <= 1'b1;
      ram_we     <= 1'b0;
      ram_addr   <= '0;
      ram_din    <= '0;
      bank_reg   <= 8'h00;
      work_q     <= '0;
      wr_cnt_q   <= '0;
      hold_cnt_q <= '0;
`ifdef TAPE_CHECKSUM_EN
      checksum_q <= 8'h00;
`endif
    end else begin
      // Popping loads the work register; RAM address/data are presented
      // right away so they lead ram_we by one cycle. Bank-port entries leave
      // the RAM outputs untouched.
      if (pop) begin
        work_q  <= head;
        state_q <= S_WRITE;
        if (head[23:8] != BANK_PORT) begin
          ram_addr <= head[23:8];
          ram_din  <= head[7:0];
        end
      end
      case (state_q)
        S_IDLE: begin
          if (!empty) begin
            busrq_n <= 1'b0;
            state_q <= S_REQ;
          end
        end
        S_REQ: ;  // advances only through pop
        S_WRITE: begin
          if (work_q[23:8] == BANK_PORT) begin
            bank_reg <= work_q[7:0];
            state_q  <= S_NEXT;
          end else if (!ram_we) begin
            ram_we   <= 1'b1;
            wr_cnt_q <= 4'(WR_CYCLES - 1);
`ifdef TAPE_CHECKSUM_EN
            checksum_q <= checksum_q + ram_din;
`endif
          end else if (wr_cnt_q == 4'd0) begin
            ram_we  <= 1'b0;
            state_q <= S_NEXT;
          end else begin
            wr_cnt_q <= wr_cnt_q - 4'd1;
          end
        end
        S_NEXT: begin
          if (!pop) begin
            hold_cnt_q <= HW'(HOLD_CYCLES - 1);
            state_q    <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (!pop) begin
            if (hold_cnt_q == '0) begin
              busrq_n <= 1'b1;
              state_q <= S_IDLE;
            end else begin
              hold_cnt_q <= hold_cnt_q - 1'b1;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tape_ram_injector.sv
// -----------------------------------------------------------------------------
// tb_tape_ram_injector
//   Directed bench for tape_ram_injector. A bus-master model answers busrq_n
//   with busak_n a few cycles later (or withholds the grant). The expected
//   RAM write sequence, bank value, overflow flag and checksum are kept as a
//   queue and plain variables; a monitor compares every RAM strobe against
//   them on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_tape_ram_injector;

  localparam int WR_CYC  = 2;
  localparam int HOLD_CY = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        tape_wr;
  logic [15:0] tape_addr;
  logic [7:0]  tape_dout;
  logic        busak_n = 1'b1;
  logic        busrq_n;
  logic [15:0] ram_addr;
  logic [7:0]  ram_din;
  logic        ram_we;
  logic [7:0]  bank_reg;
  logic        overflow;
  logic [7:0]  checksum;
  logic [2:0]  dbg_state;

  tape_ram_injector #(.FIFO_AW(2), .WR_CYCLES(WR_CYC), .HOLD_CYCLES(HOLD_CY)) dut (
    .clk(clk), .reset(reset), .tape_wr(tape_wr), .tape_addr(tape_addr),
    .tape_dout(tape_dout), .busak_n(busak_n), .busrq_n(busrq_n),
    .ram_addr(ram_addr), .ram_din(ram_din), .ram_we(ram_we),
    .bank_reg(bank_reg), .overflow(overflow), .checksum(checksum),
    .dbg_state(dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- bus master model ----------------
  logic       grant_en = 1'b1;
  logic [2:0] rq_sr = 3'b111;
  always @(negedge clk) begin
    rq_sr   <= {rq_sr[1:0], busrq_n};
    busak_n <= grant_en ? rq_sr[2] : 1'b1;
  end

  // ---------------- scoreboard / model ----------------
  logic [23:0] exp_q[$];
  logic [7:0]  exp_sum  = 8'h00;
  logic [7:0]  exp_bank = 8'h00;
  logic        exp_ovf  = 1'b0;
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic expect_ram(input logic [15:0] a, input logic [7:0] d);
    exp_q.push_back({a, d});
    exp_sum = exp_sum + d;
  endtask

  task automatic model_reset();
    exp_q.delete();
    exp_sum  = 8'h00;
    exp_bank = 8'h00;
    exp_ovf  = 1'b0;
  endtask

  // ---------------- monitor ----------------
  logic        prev_we = 1'b0;
  logic        prev_rq = 1'b1;
  logic [15:0] prev_addr = '0;
  logic [7:0]  prev_din  = '0;
  int pw = 0;
  int pulse_cnt = 0;
  int rq_falls = 0;
  int low_run = 0;
  int last_low_run = 0;

  always @(negedge clk) begin
    if (reset) begin
      pw      = 0;
      low_run = 0;
    end else begin
      if (ram_we && !prev_we) begin
        pulse_cnt++;
        pw = 1;
        if (exp_q.size() == 0) begin
          chk("unexpected_ram_we", {8'h00, ram_addr, ram_din}, 32'hFFFFFFFF);
        end else begin
          chk("ram_write_pair", {8'h00, ram_addr, ram_din}, {8'h00, exp_q.pop_front()});
        end
        chk("addr_setup", {8'h00, prev_addr, prev_din}, {8'h00, ram_addr, ram_din});
      end else if (ram_we && prev_we) begin
        pw++;
        chk("addr_hold", {8'h00, prev_addr, prev_din}, {8'h00, ram_addr, ram_din});
      end
      if (!ram_we && prev_we) chk("we_width", pw, WR_CYC);
      if (ram_we) chk("busrq_during_we", busrq_n, 1'b0);
      if (prev_rq && !busrq_n) rq_falls++;
      if (!busrq_n) low_run++;
      if (busrq_n && !prev_rq) begin
        last_low_run = low_run;
        low_run = 0;
      end
    end
    prev_we   = ram_we;
    prev_rq   = busrq_n;
    prev_addr = ram_addr;
    prev_din  = ram_din;
  end

  // ---------------- driver ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic wr, input logic [15:0] a, input logic [7:0] d, input int n);
    tape_wr   = wr;
    tape_addr = a;
    tape_dout = d;
    tick(n);
  endtask

  task automatic check_state(input string tag);
    logic [7:0] exp_ck;
`ifdef TAPE_CHECKSUM_EN
    exp_ck = exp_sum;
`else
    exp_ck = 8'h00;
`endif
    chk({tag, "_bank"}, bank_reg, exp_bank);
    chk({tag, "_ovf"}, overflow, exp_ovf);
    chk({tag, "_cksum"}, checksum, exp_ck);
    chk({tag, "_drained"}, exp_q.size(), 0);
  endtask

  int p0;
  bit seen;

  initial begin
    reset = 1'b1; tape_wr = 1'b0; tape_addr = '0; tape_dout = '0;
    tick(3);
    reset = 1'b0;
    // reset state
    chk("rst_busrq", busrq_n, 1'b1);
    chk("rst_we", ram_we, 1'b0);
    chk("rst_addr", ram_addr, 16'h0000);
    chk("rst_din", ram_din, 8'h00);
    chk("rst_bank", bank_reg, 8'h00);
    chk("rst_ovf", overflow, 1'b0);
    chk("rst_cksum", checksum, 8'h00);

    // 1: bank-port write, no RAM strobe, bus released after hold period
    rq_falls = 0; p0 = pulse_cnt;
    drive(1'b1, 16'hFFFF, 8'h00, 3);
    drive(1'b0, 16'hFFFF, 8'h00, 40);
    exp_bank = 8'h00;
    check_state("t1");
    chk("t1_no_we", pulse_cnt - p0, 0);
    chk("t1_busrq_released", busrq_n, 1'b1);
    chk("t1_one_request", rq_falls, 1);
    chk("t1_low_min", (last_low_run >= HOLD_CY), 1'b1);
    chk("t1_low_max", (last_low_run <= HOLD_CY + 10), 1'b1);

    // 2: three bytes, closer together than the hold time -> one bus tenure
    rq_falls = 0; p0 = pulse_cnt;
    expect_ram(16'h694C, 8'h11);
    expect_ram(16'h694D, 8'h22);
    expect_ram(16'h694E, 8'h33);
    drive(1'b1, 16'h694C, 8'h11, 6);
    drive(1'b1, 16'h694D, 8'h22, 6);
    drive(1'b1, 16'h694E, 8'h33, 6);
    drive(1'b0, 16'h694E, 8'h33, 40);
    check_state("t2");
    chk("t2_pulses", pulse_cnt - p0, 3);
    chk("t2_one_request", rq_falls, 1);
    chk("t2_last_addr", ram_addr, 16'h694E);

    // 3: grant withheld, six distinct writes -> four queued, overflow
    grant_en = 1'b0; p0 = pulse_cnt;
    for (int i = 0; i < 6; i++) begin
      if (i < 4) expect_ram(16'h7000 + 16'(i), 8'hA0 + 8'(i));
      drive(1'b1, 16'h7000 + 16'(i), 8'hA0 + 8'(i), 1);
    end
    drive(1'b0, 16'h7000, 8'h00, 20);
    exp_ovf = 1'b1;
    chk("t3_no_we", pulse_cnt - p0, 0);
    chk("t3_ovf", overflow, 1'b1);
    chk("t3_busrq_pending", busrq_n, 1'b0);
    grant_en = 1'b1;
    tick(40);
    check_state("t3");
    chk("t3_pulses", pulse_cnt - p0, 4);

    // 4: repeated pair while tape_wr high is one write; a 1-0-1 toggle is another
    p0 = pulse_cnt;
    expect_ram(16'h7100, 8'h5C);
    expect_ram(16'h7100, 8'h5C);
    drive(1'b1, 16'h7100, 8'h5C, 5);
    drive(1'b0, 16'h7100, 8'h5C, 1);
    drive(1'b1, 16'h7100, 8'h5C, 3);
    drive(1'b0, 16'h7100, 8'h5C, 40);
    check_state("t4");
    chk("t4_pulses", pulse_cnt - p0, 2);

    // 5: reset during a RAM strobe; queued byte is flushed
    p0 = pulse_cnt;
    expect_ram(16'h7200, 8'h01);
    drive(1'b1, 16'h7200, 8'h01, 1);
    drive(1'b1, 16'h7201, 8'h02, 1);
    drive(1'b0, 16'h7201, 8'h02, 0);
    seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clk); #1;
      if (ram_we) seen = 1'b1;
    end
    chk("t5_we_seen", seen, 1'b1);
    reset = 1'b1;
    model_reset();
    tick(1);
    chk("t5_we_drop", ram_we, 1'b0);
    chk("t5_busrq_rel", busrq_n, 1'b1);
    tick(1);
    reset = 1'b0;
    rq_falls = 0;
    tick(30);
    chk("t5_pulses", pulse_cnt - p0, 1);
    chk("t5_no_request", rq_falls, 0);
    check_state("t5");

    // 6: checksum over RAM bytes only, bank-port byte excluded
    expect_ram(16'h7300, 8'hF0);
    expect_ram(16'h7301, 8'h20);
    drive(1'b1, 16'h7300, 8'hF0, 1);
    drive(1'b1, 16'h7301, 8'h20, 1);
    drive(1'b1, 16'hFFFF, 8'h55, 1);
    drive(1'b0, 16'hFFFF, 8'h55, 40);
    exp_bank = 8'h55;
    check_state("t6");
    chk("t6_bank_lit", bank_reg, 8'h55);
`ifdef TAPE_CHECKSUM_EN
    chk("t6_cksum_lit", checksum, 8'h10);
`else
    chk("t6_cksum_lit", checksum, 8'h00);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
